ifu_decoupled: RTL and testbench

Parametrised instruction fetch unit that decouples fetch from decode with a QDEPTH-entry instruction queue. It supports multiple outstanding in-order fetches and a selectable static branch predictor, and it discards stale responses after a flush or redirect. It sits between the instruction cache/bus port and the decode stage, and receives flushes from the jump and CSR/exception paths.

---
 rtl/ifu_pkg.sv | 27 ++
 rtl/ifu_inst_queue.sv | 54 +++++
 rtl/ifu_decoupled.sv | 128 ++++++++++++
 tb/tb_ifu_decoupled.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types, opcode constants and immediate decoders for the decoupled fetch unit.
package ifu_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    typedef enum logic [1:0] {
        PRED_NONE     = 2'd0,
        PRED_BTFN     = 2'd1,
        PRED_BTFN_JAL = 2'd2
    } pred_mode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
    } q_entry_t;

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_inst_queue.sv
// Synchronous instruction FIFO with a clear input; head is read from registered storage.
module ifu_inst_queue
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = q_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enq,
    input  entry_t                 enq_data,
    input  logic                   deq,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_enq;
    logic          do_deq;

    assign do_enq = enq && !clear;
    assign do_deq = deq && !clear && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // The fetch credit scheme must never let a write land in a full queue.
            if (do_enq && !do_deq) assert (count != CW'(DEPTH));
            if (do_enq) wr_ptr <= wr_ptr + AW'(1);
            if (do_deq) rd_ptr <= rd_ptr + AW'(1);
            if (do_enq && !do_deq)      count <= count + CW'(1);
            else if (!do_enq && do_deq) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/ifu_decoupled.sv
// Instruction fetch unit: in-order multi-outstanding fetch, static prediction, stale-response dropping.
module ifu_decoupled
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h3000_0000,
    parameter int          QDEPTH    = 4,
    parameter int          MAX_OUTST = 2,
    parameter int          PRED_MODE = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        fetch_req_valid,
    input  logic        fetch_req_ready,
    output logic [31:0] fetch_req_addr,
    input  logic        fetch_resp_valid,
    input  logic [31:0] fetch_resp_inst,
    input  logic        jump_flush,
    input  logic [31:0] jump_dnpc,
    input  logic        cs_flush,
    input  logic [31:0] cs_dnpc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_pred_taken
);

    localparam int         CW   = $clog2(MAX_OUTST + 1);
    localparam int         QW   = $clog2(QDEPTH) + 1;
    localparam pred_mode_e MODE = pred_mode_e'(PRED_MODE);

    logic [31:0]        fetch_pc;
    logic [31:0]        resp_pc;
    logic [31:0]        dnpc;
    logic [31:0]        target;
    logic signed [31:0] imm;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      inflight_next;
    logic [CW-1:0]      drop_cnt;
    logic [QW-1:0]      q_count;
    q_entry_t           q_head;
    q_entry_t           q_in;
    logic               flush;
    logic               resp_ok;
    logic               accept;
    logic               discard;
    logic               is_b;
    logic               is_jal;
    logic               redirect;
    logic               issue;
    logic               deq;
    logic               has_head;

    assign flush = cs_flush | jump_flush;
    assign dnpc  = cs_flush ? cs_dnpc : jump_dnpc;

    // A response with nothing outstanding is a leftover from before reset and is ignored.
    assign resp_ok = fetch_resp_valid && (inflight != '0);
    assign accept  = resp_ok && (drop_cnt == '0) && !flush;
    assign discard = resp_ok && (drop_cnt != '0);

    assign is_b     = (MODE != PRED_NONE) && (fetch_resp_inst[6:2] == OP_BRANCH) && fetch_resp_inst[31];
    assign is_jal   = (MODE == PRED_BTFN_JAL) && (fetch_resp_inst[6:2] == OP_JAL);
    assign redirect = accept && (is_b || is_jal);
    assign imm      = is_jal ? imm_j(fetch_resp_inst) : imm_b(fetch_resp_inst);
    assign target   = resp_pc + $unsigned(imm);

    // Every non-stale in-flight fetch holds a reserved queue slot.
    assign fetch_req_valid = reset && !flush && !redirect
                          && (32'(inflight) < MAX_OUTST)
                          && (32'(q_count) + 32'(inflight) - 32'(drop_cnt) < 32'(QDEPTH));
    assign fetch_req_addr  = fetch_pc;
    assign issue           = fetch_req_valid && fetch_req_ready;

    always_comb begin
        inflight_next = inflight;
        if (issue && !resp_ok)      inflight_next = inflight + CW'(1);
        else if (!issue && resp_ok) inflight_next = inflight - CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (flush) begin
                fetch_pc <= dnpc;
                resp_pc  <= dnpc;
                drop_cnt <= inflight_next;
            end else if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= inflight_next;
            end else begin
                if (issue)   fetch_pc <= fetch_pc + 32'd4;
                if (accept)  resp_pc  <= resp_pc + 32'd4;
                if (discard) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    assign q_in = '{pc: resp_pc, inst: fetch_resp_inst, pred_taken: redirect};

    ifu_inst_queue #(
        .DEPTH   (QDEPTH),
        .entry_t (q_entry_t)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .enq      (accept),
        .enq_data (q_in),
        .deq      (deq),
        .head     (q_head),
        .count    (q_count)
    );

    assign has_head       = (q_count != '0);
    assign out_valid      = has_head && !flush;
    assign deq            = out_valid && out_ready;
    assign out_pc         = has_head ? q_head.pc : '0;
    assign out_inst       = has_head ? q_head.inst : '0;
    assign out_pred_taken = has_head && q_head.pred_taken;

endmodule

// File: tb/tb_ifu_decoupled.sv
// Directed bench for ifu_decoupled with an in-order fixed-latency fetch responder.
module tb_ifu_decoupled;

    localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_req_addr;
    logic        fetch_resp_valid;
    logic [31:0] fetch_resp_inst;
    logic        jump_flush;
    logic [31:0] jump_dnpc;
    logic        cs_flush;
    logic [31:0] cs_dnpc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pend[$];
    int   cyc      = 0;
    int   lat      = 1;
    int   last_due = 0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 clock = ~clock;

    ifu_decoupled dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_req_addr   (fetch_req_addr),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_inst  (fetch_resp_inst),
        .jump_flush       (jump_flush),
        .jump_dnpc        (jump_dnpc),
        .cs_flush         (cs_flush),
        .cs_dnpc          (cs_dnpc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_inst         (out_inst),
        .out_pred_taken   (out_pred_taken)
    );

    // Program image: ADDI-format words tagged with the address, one backward beq.
    function automatic logic [31:0] prog(input logic [31:0] addr);
        if (addr == 32'h8000_0010) return BEQ_M16;
        return {addr[23:4], 12'h013};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Finish the current cycle: log a handshake, clock, then present any due response.
    task automatic cycle_end();
        int d;
        #1;
        if (fetch_req_valid && fetch_req_ready) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{fetch_req_addr, d});
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
        jump_flush = 1'b0;
        cs_flush   = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            fetch_resp_valid = 1'b1;
            fetch_resp_inst  = prog(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            fetch_resp_valid = 1'b0;
            fetch_resp_inst  = 32'h0;
        end
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc, input logic pred);
        int n = 0;
        while (!out_valid && n < 30) begin
            cycle_end();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_inst"}, out_inst, prog(pc));
        chk({tag, "_pred"}, 32'(out_pred_taken), 32'(pred));
        cycle_end();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int infl;
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b0;
        fetch_resp_inst  = 32'h0;
        jump_flush       = 1'b0;
        jump_dnpc        = 32'h0;
        cs_flush         = 1'b0;
        cs_dnpc          = 32'h0;
        out_ready        = 1'b0;
        #2 reset = 1'b0;
        @(negedge clock);
        #1;
        repeat (2) cycle_end();

        chk("rst_req_valid", 32'(fetch_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pred", 32'(out_pred_taken), 32'd0);

        // Streaming with single-cycle responses.
        fetch_req_ready = 1'b1;
        out_ready       = 1'b1;
        lat             = 1;
        reset           = 1'b1;
        #1;
        chk("first_req_valid", 32'(fetch_req_valid), 32'd1);
        chk("first_req_addr", fetch_req_addr, 32'h3000_0000);
        pop_check("seq0", 32'h3000_0000, 1'b0);
        pop_check("seq1", 32'h3000_0004, 1'b0);
        pop_check("seq2", 32'h3000_0008, 1'b0);
        pop_check("seq3", 32'h3000_000C, 1'b0);

        // Decode stalls: queue fills to depth and fetch stops.
        out_ready = 1'b0;
        #1;
        repeat (10) cycle_end();
        chk("full_no_req", 32'(fetch_req_valid), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head", out_pc, 32'h3000_0010);
        out_ready = 1'b1;
        #1;
        chk("full_deq_no_req", 32'(fetch_req_valid), 32'd0);
        pop_check("full0", 32'h3000_0010, 1'b0);
        pop_check("full1", 32'h3000_0014, 1'b0);
        pop_check("full2", 32'h3000_0018, 1'b0);
        pop_check("full3", 32'h3000_001C, 1'b0);
        pop_check("full4", 32'h3000_0020, 1'b0);

        // Jump flush with two fetches in flight at latency 3.
        lat = 3;
        n = 0;
        while (!(pend.size() == 2 && !fetch_resp_valid) && n < 40) begin
            cycle_end();
            n++;
        end
        chk("two_inflight", 32'(pend.size()), 32'd2);
        jump_flush = 1'b1;
        jump_dnpc  = 32'h8000_0100;
        #1;
        chk("jf_out_valid", 32'(out_valid), 32'd0);
        chk("jf_no_req", 32'(fetch_req_valid), 32'd0);
        cycle_end();
        pop_check("jf0", 32'h8000_0100, 1'b0);
        pop_check("jf1", 32'h8000_0104, 1'b0);

        // Backward beq at 0x80000010 loops to 0x80000000; younger fetch dropped.
        lat        = 2;
        jump_flush = 1'b1;
        jump_dnpc  = 32'h8000_0000;
        #1;
        cycle_end();
        pop_check("br0", 32'h8000_0000, 1'b0);
        pop_check("br1", 32'h8000_0004, 1'b0);
        pop_check("br2", 32'h8000_0008, 1'b0);
        pop_check("br3", 32'h8000_000C, 1'b0);
        pop_check("br_taken", 32'h8000_0010, 1'b1);
        pop_check("br_target", 32'h8000_0000, 1'b0);
        n = 0;
        while (!(fetch_resp_valid && fetch_resp_inst == BEQ_M16) && n < 40) begin
            cycle_end();
            n++;
        end
        chk("redir_seen", fetch_resp_inst, BEQ_M16);
        chk("redir_no_req", 32'(fetch_req_valid), 32'd0);
        cycle_end();
        chk("redir_req_valid", 32'(fetch_req_valid), 32'd1);
        chk("redir_req_addr", fetch_req_addr, 32'h8000_0000);
        pop_check("br2_taken", 32'h8000_0010, 1'b1);
        pop_check("br2_target", 32'h8000_0000, 1'b0);

        // Simultaneous CSR and jump flush while a response returns.
        n = 0;
        while (!fetch_resp_valid && n < 40) begin
            cycle_end();
            n++;
        end
        chk("both_resp_present", 32'(fetch_resp_valid), 32'd1);
        cs_flush   = 1'b1;
        cs_dnpc    = 32'h9000_0000;
        jump_flush = 1'b1;
        jump_dnpc  = 32'hA000_0000;
        #1;
        chk("both_out_valid", 32'(out_valid), 32'd0);
        chk("both_no_req", 32'(fetch_req_valid), 32'd0);
        cycle_end();
        infl = pend.size() + (fetch_resp_valid ? 1 : 0);
        chk("both_req_valid", 32'(fetch_req_valid), 32'(infl < 2));
        if (fetch_req_valid) chk("both_req_addr", fetch_req_addr, 32'h9000_0000);
        pop_check("cs0", 32'h9000_0000, 1'b0);
        pop_check("cs1", 32'h9000_0004, 1'b0);

        // Reset asserted mid-burst with entries queued.
        pop_check("pre_rst", 32'h9000_0008, 1'b0);
        out_ready = 1'b0;
        #1;
        repeat (4) cycle_end();
        chk("pre_rst_queued", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(fetch_req_valid), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_pc", out_pc, 32'h0);
        chk("mid_rst_out_inst", out_inst, 32'h0);
        repeat (3) cycle_end();
        chk("held_rst_req_valid", 32'(fetch_req_valid), 32'd0);
        out_ready = 1'b1;
        reset     = 1'b1;
        #1;
        chk("restart_req_valid", 32'(fetch_req_valid), 32'd1);
        chk("restart_req_addr", fetch_req_addr, 32'h3000_0000);
        pop_check("rs0", 32'h3000_0000, 1'b0);
        pop_check("rs1", 32'h3000_0004, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
